// File: rtl/dmi_req_sequencer.sv
// Pops DMI request words from the DTM->DM FIFO and runs each one as a single
// register access with a timeout. Every pop produces one response word.
module dmi_req_sequencer #(
  parameter int ABITS          = 7,
  parameter int ADDR_LIMIT     = 'h7F,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_req_empty,
  output logic               o_req_ren,
  input  logic [ABITS+33:0]  i_req_data,
  input  logic               i_resp_full,
  output logic               o_resp_wen,
  output logic [ABITS+33:0]  o_resp_data,
  output logic               o_reg_req,
  output logic               o_reg_we,
  output logic [ABITS-1:0]   o_reg_addr,
  output logic [31:0]        o_reg_wdata,
  input  logic               i_reg_ack,
  input  logic [31:0]        i_reg_rdata,
  input  logic               i_reg_err,
  output logic               o_busy
);
  localparam logic [ABITS-1:0] LIMIT   = ABITS'(ADDR_LIMIT);
  localparam logic [16:0]      TMO     = 17'(TIMEOUT_CYCLES);
  localparam logic [1:0]       OP_NOP  = 2'd0;
  localparam logic [1:0]       OP_RD   = 2'd1;
  localparam logic [1:0]       OP_WR   = 2'd2;
  localparam logic [1:0]       ST_OK   = 2'd0;
  localparam logic [1:0]       ST_FAIL = 2'd2;

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, RESP = 2'd2} state_t;

  state_t r_state, w_state;

  logic               r_req_ren, w_req_ren;
  logic               r_resp_wen, w_resp_wen;
  logic [ABITS+33:0]  r_resp_data, w_resp_data;
  logic               r_reg_req, w_reg_req;
  logic               r_reg_we, w_reg_we;
  logic [ABITS-1:0]   r_reg_addr, w_reg_addr;
  logic [31:0]        r_reg_wdata, w_reg_wdata;
  logic               r_busy, w_busy;
  logic [31:0]        r_rdata, w_rdata;
  logic [1:0]         r_status, w_status;
  logic [15:0]        r_cnt, w_cnt;
  logic [16:0]        w_cnt_inc;

  logic [ABITS-1:0]   w_in_addr;
  logic [31:0]        w_in_data;
  logic [1:0]         w_in_op;

  assign w_in_addr = i_req_data[ABITS+33:34];
  assign w_in_data = i_req_data[33:2];
  assign w_in_op   = i_req_data[1:0];
  assign w_cnt_inc = {1'b0, r_cnt} + 17'd1;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_state;
  end

  always_comb begin
    w_state     = r_state;
    w_req_ren   = 1'b0;
    w_resp_wen  = 1'b0;
    w_resp_data = r_resp_data;
    w_reg_req   = r_reg_req;
    w_reg_we    = r_reg_we;
    w_reg_addr  = r_reg_addr;
    w_reg_wdata = r_reg_wdata;
    w_rdata     = r_rdata;
    w_status    = r_status;
    w_cnt       = r_cnt;
    case (r_state)
      IDLE: begin
        if (!i_req_empty) begin
          w_req_ren   = 1'b1;
          w_reg_addr  = w_in_addr;
          w_reg_wdata = w_in_data;
          w_reg_we    = (w_in_op == OP_WR);
          w_rdata     = '0;
          w_cnt       = '0;
          if ((w_in_op == OP_RD || w_in_op == OP_WR) && w_in_addr <= LIMIT) begin
            w_state   = ISSUE;
            w_reg_req = 1'b1;
          end else begin
            w_state  = RESP;
            w_status = (w_in_op == OP_NOP) ? ST_OK : ST_FAIL;
          end
        end
      end
      ISSUE: begin
        // an ack in the cycle the count expires still completes the access
        if (i_reg_ack && r_reg_req) begin
          w_reg_req = 1'b0;
          w_state   = RESP;
          w_cnt     = '0;
          w_rdata   = r_reg_we ? 32'h0 : i_reg_rdata;
          w_status  = i_reg_err ? ST_FAIL : ST_OK;
        end else if (w_cnt_inc >= TMO) begin
          w_reg_req = 1'b0;
          w_state   = RESP;
          w_cnt     = '0;
          w_rdata   = '0;
          w_status  = ST_FAIL;
        end else begin
          w_cnt = w_cnt_inc[15:0];
        end
      end
      RESP: begin
        if (!i_resp_full) begin
          w_resp_wen  = 1'b1;
          w_resp_data = {r_reg_addr, r_rdata, r_status};
          w_state     = IDLE;
        end
      end
      default: w_state = IDLE;
    endcase
    w_busy = (w_state != IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_req_ren   <= 1'b0;
      r_resp_wen  <= 1'b0;
      r_resp_data <= '0;
      r_reg_req   <= 1'b0;
      r_reg_we    <= 1'b0;
      r_reg_addr  <= '0;
      r_reg_wdata <= '0;
      r_busy      <= 1'b0;
      r_rdata     <= '0;
      r_status    <= '0;
      r_cnt       <= '0;
    end else begin
      r_req_ren   <= w_req_ren;
      r_resp_wen  <= w_resp_wen;
      r_resp_data <= w_resp_data;
      r_reg_req   <= w_reg_req;
      r_reg_we    <= w_reg_we;
      r_reg_addr  <= w_reg_addr;
      r_reg_wdata <= w_reg_wdata;
      r_busy      <= w_busy;
      r_rdata     <= w_rdata;
      r_status    <= w_status;
      r_cnt       <= w_cnt;
    end
  end

  assign o_req_ren   = r_req_ren;
  assign o_resp_wen  = r_resp_wen;
  assign o_resp_data = r_resp_data;
  assign o_reg_req   = r_reg_req;
  assign o_reg_we    = r_reg_we;
  assign o_reg_addr  = r_reg_addr;
  assign o_reg_wdata = r_reg_wdata;
  assign o_busy      = r_busy;

endmodule

// File: tb/tb_dmi_req_sequencer.sv
// Scoreboard bench: FWFT request FIFO model, register responder, response queue.
module tb_dmi_req_sequencer;
  localparam int AB  = 8;
  localparam int W   = AB + 34;
  localparam int TMO = 4;

  logic          clk = 1'b0, rst = 1'b1;
  logic          req_empty = 1'b1, resp_full = 1'b0;
  logic [W-1:0]  req_data = '0;
  logic          reg_ack = 1'b0, reg_err = 1'b0;
  logic [31:0]   reg_rdata = '0;
  logic          req_ren, resp_wen, reg_req, reg_we, busy;
  logic [W-1:0]  resp_data;
  logic [AB-1:0] reg_addr;
  logic [31:0]   reg_wdata;

  always #5 clk = ~clk;

  dmi_req_sequencer #(.ABITS(AB), .ADDR_LIMIT('h7F), .TIMEOUT_CYCLES(TMO)) dut (
    .i_clk(clk), .i_rst(rst), .i_req_empty(req_empty), .o_req_ren(req_ren),
    .i_req_data(req_data), .i_resp_full(resp_full), .o_resp_wen(resp_wen),
    .o_resp_data(resp_data), .o_reg_req(reg_req), .o_reg_we(reg_we),
    .o_reg_addr(reg_addr), .o_reg_wdata(reg_wdata), .i_reg_ack(reg_ack),
    .i_reg_rdata(reg_rdata), .i_reg_err(reg_err), .o_busy(busy)
  );

  typedef struct {
    logic [7:0]  addr;
    logic        we;
    logic [31:0] wdata;
    int          len;
    int          ack_at;
    logic [31:0] rdata;
    logic        err;
  } acc_t;

  logic [W-1:0] req_q[$];
  logic [W-1:0] exp_q[$];
  acc_t         acc_q[$];
  acc_t         cur;
  int n_tests = 0, n_fail = 0;
  int rcnt = 0, n_ren = 0, n_wen = 0, n_sent = 0, n_exp = 0;
  logic spur = 1'b0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [W-1:0] model(input logic [7:0] a, input logic [1:0] op,
                                         input int ack_at, input logic [31:0] rd, input logic err);
    if (op == 2'd0) return {a, 32'h0, 2'd0};
    if (op == 2'd3 || a > 8'h7F) return {a, 32'h0, 2'd2};
    if (ack_at == 0 || ack_at > TMO) return {a, 32'h0, 2'd2};
    return {a, (op == 2'd1) ? rd : 32'h0, err ? 2'd2 : 2'd0};
  endfunction

  task automatic send(input logic [7:0] a, input logic [1:0] op, input logic [31:0] d,
                      input int ack_at, input logic [31:0] rd, input logic err,
                      input bit exp_resp, input int len_ovr);
    acc_t x;
    req_q.push_back({a, d, op});
    n_sent++;
    if ((op == 2'd1 || op == 2'd2) && a <= 8'h7F) begin
      x.addr = a; x.we = (op == 2'd2); x.wdata = d; x.ack_at = ack_at;
      x.rdata = rd; x.err = err;
      x.len = (len_ovr != 0) ? len_ovr : ((ack_at == 0 || ack_at > TMO) ? TMO : ack_at);
      acc_q.push_back(x);
    end
    if (exp_resp) begin
      exp_q.push_back(model(a, op, ack_at, rd, err));
      n_exp++;
    end
  endtask

  task automatic wait_idle(input string tag);
    int i;
    for (i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (req_q.size() == 0 && exp_q.size() == 0 && acc_q.size() == 0 && !busy && rcnt == 0) break;
    end
    chk({tag, "_done"}, 64'(i < 200), 1);
  endtask

  // FIFO pop, response scoreboard and register responder, all on the idle edge
  always @(negedge clk) begin
    if (req_ren) begin
      n_ren++;
      if (req_empty) chk("ren_on_empty", 1, 0);
      if (req_q.size() != 0) void'(req_q.pop_front());
    end
    if (resp_wen) begin
      n_wen++;
      if (resp_full) chk("wen_on_full", 1, 0);
      if (req_ren) chk("ren_wen_overlap", 1, 0);
      if (exp_q.size() == 0) chk("resp_unexpected", 1, 0);
      else chk("resp", resp_data, exp_q.pop_front());
    end
    if (reg_req) begin
      if (rcnt == 0) begin
        if (acc_q.size() == 0) begin
          chk("reg_req_unexpected", 1, 0);
          cur.ack_at = 0; cur.len = 0; cur.err = 0; cur.rdata = '0;
        end else begin
          cur = acc_q.pop_front();
          chk("reg_addr", reg_addr, cur.addr);
          chk("reg_we", reg_we, cur.we);
          if (cur.we) chk("reg_wdata", reg_wdata, cur.wdata);
        end
      end
      rcnt++;
      reg_ack   = (cur.ack_at != 0 && rcnt == cur.ack_at);
      reg_rdata = reg_ack ? cur.rdata : 32'hA5A5_0000 + 32'(rcnt);
      reg_err   = reg_ack && cur.err;
    end else begin
      if (rcnt > 0) chk("reg_req_len", rcnt, cur.len);
      rcnt      = 0;
      reg_ack   = spur;
      reg_err   = spur;
      reg_rdata = 32'hBAD0_BAD0;
    end
    req_empty = (req_q.size() == 0);
    req_data  = req_empty ? '0 : req_q[0];
  end

  initial begin
    int rens, wens, i;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ren", req_ren, 0);
    chk("rst_wen", resp_wen, 0);
    chk("rst_reg_req", reg_req, 0);
    chk("rst_reg_we", reg_we, 0);
    chk("rst_busy", busy, 0);
    chk("rst_addr", reg_addr, 0);
    chk("rst_wdata", reg_wdata, 0);
    chk("rst_resp_data", resp_data, 0);
    rst = 1'b0;

    send(8'h11, 2'd1, 32'h0, 2, 32'hDEADBEEF, 1'b0, 1, 0);
    wait_idle("read");
    chk("busy_after_read", busy, 0);

    send(8'h04, 2'd2, 32'h12345678, 1, 32'h0, 1'b1, 1, 0);
    wait_idle("write_err");

    send(8'h05, 2'd0, 32'h1111_1111, 0, 32'h0, 1'b0, 1, 0);
    send(8'h06, 2'd3, 32'h2222_2222, 0, 32'h0, 1'b0, 1, 0);
    send(8'h80, 2'd1, 32'h0, 1, 32'h3333_3333, 1'b0, 1, 0);
    wait_idle("nop_rsvd_range");

    send(8'h20, 2'd1, 32'h0, 0, 32'h0, 1'b0, 1, 0);
    wait_idle("timeout");
    send(8'h21, 2'd1, 32'h0, 4, 32'hCAFEF00D, 1'b0, 1, 0);
    wait_idle("ack_at_limit");
    send(8'h7F, 2'd2, 32'hFFFF_0001, 3, 32'h0, 1'b0, 1, 0);
    wait_idle("write_top_addr");

    resp_full = 1'b1;
    send(8'h30, 2'd0, 32'h0, 0, 32'h0, 1'b0, 1, 0);
    send(8'h31, 2'd1, 32'h0, 1, 32'h0BAD_CAFE, 1'b0, 1, 0);
    for (i = 0; i < 50 && !busy; i++) begin @(posedge clk); #1; end
    chk("full_busy_seen", busy, 1);
    rens = 0; wens = 0;
    repeat (10) begin
      @(posedge clk); #1;
      rens += int'(req_ren);
      wens += int'(resp_wen);
    end
    chk("full_no_wen", wens, 0);
    chk("full_no_pop", rens, 0);
    resp_full = 1'b0;
    @(posedge clk); #1;
    chk("full_release_wen", resp_wen, 1);
    wait_idle("resp_full");

    spur = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("spurious_ack_busy", busy, 0);
    spur = 1'b0;
    @(posedge clk); #1;

    send(8'h22, 2'd1, 32'h0, 0, 32'h0, 1'b0, 0, 2);
    send(8'h23, 2'd2, 32'h0000_55AA, 1, 32'h0, 1'b0, 1, 0);
    for (i = 0; i < 50 && !reg_req; i++) begin @(posedge clk); #1; end
    chk("rst_test_req_seen", reg_req, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_reg_req", reg_req, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_wen", resp_wen, 0);
    rst = 1'b0;
    wait_idle("after_reset");

    chk("n_ren", n_ren, n_sent);
    chk("n_wen", n_wen, n_exp);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
